// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StFull  = 2'b01,
        StSkid  = 2'b10
    } stage_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between fetch and decode, with an optional
// 2-entry skid buffer so in_ready_o can be driven straight from a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     XLEN = 32,
    parameter logic [XLEN-1:0] NOP  = XLEN'(NOP_INSTR),
    parameter bit              SKID = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    stage_state_e    state_q, state_d;
    logic [XLEN-1:0] main_instr_q, main_pc_q;
    logic            accept, take;

    assign out_valid_o = (state_q != StEmpty);
    assign accept      = in_valid_i && in_ready_o;
    assign take        = out_valid_o && out_ready_i;

    // Outputs only ever come from the main register, never from instr_i/pc_i.
    assign instr_o = out_valid_o ? main_instr_q : NOP;
    assign pc_o    = out_valid_o ? main_pc_q : '0;

    if (SKID) begin : g_skid
        logic            in_ready_q;
        logic [XLEN-1:0] skid_instr_q, skid_pc_q;
        logic            load_main, load_skid, main_from_skid;

        assign in_ready_o = in_ready_q;

        always_comb begin
            state_d        = state_q;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StFull;
                        load_main = 1'b1;
                    end
                end
                StFull: begin
                    if (accept && take) begin
                        load_main = 1'b1;
                    end else if (take) begin
                        state_d = StEmpty;
                    end else if (accept) begin
                        state_d   = StSkid;
                        load_skid = 1'b1;
                    end
                end
                StSkid: begin
                    if (take) begin
                        state_d        = StFull;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
            // Redirect drops everything, including a same-cycle accept.
            if (flush_i) begin
                state_d   = StEmpty;
                load_main = 1'b0;
                load_skid = 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q    <= StEmpty;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                in_ready_q <= (state_d != StSkid);
                if (load_main) begin
                    main_instr_q <= main_from_skid ? skid_instr_q : instr_i;
                    main_pc_q    <= main_from_skid ? skid_pc_q : pc_i;
                end
                if (load_skid) begin
                    skid_instr_q <= instr_i;
                    skid_pc_q    <= pc_i;
                end
            end
        end
    end else begin : g_single
        logic load_main;

        // Combinational ready: a full register can refill in the cycle it drains.
        assign in_ready_o = !out_valid_o || out_ready_i;

        always_comb begin
            state_d   = state_q;
            load_main = 1'b0;
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StFull;
                        load_main = 1'b1;
                    end
                end
                StFull: begin
                    if (accept) begin
                        load_main = 1'b1;
                    end else if (take) begin
                        state_d = StEmpty;
                    end
                end
                default: state_d = StEmpty;
            endcase
            if (flush_i) begin
                state_d   = StEmpty;
                load_main = 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= StEmpty;
            end else begin
                state_q <= state_d;
                if (load_main) begin
                    main_instr_q <= instr_i;
                    main_pc_q    <= pc_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: SKID=1 instance checked through an expected-order queue,
// SKID=0 instance checked with directed probes of its combinational ready.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOPW = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] instr_in = '0, pc_in = '0;
    logic        in_ready, out_valid;
    logic [31:0] instr_out, pc_out;

    logic        fl0 = 1'b0, v0 = 1'b0, ordy0 = 1'b0;
    logic [31:0] ins0 = '0, pci0 = '0;
    logic        rdy0, ov0;
    logic [31:0] io0, po0;

    item_t sb_q[$];
    item_t exp_item;
    int    n_chk = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.XLEN(32), .NOP(NOPW), .SKID(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr_in), .pc_i(pc_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .instr_o(instr_out), .pc_o(pc_out)
    );

    pipe_stage_reg #(.XLEN(32), .NOP(NOPW), .SKID(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl0),
        .in_valid_i(v0), .in_ready_o(rdy0),
        .instr_i(ins0), .pc_i(pci0),
        .out_valid_o(ov0), .out_ready_i(ordy0),
        .instr_o(io0), .pc_o(po0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One cycle of stimulus on the SKID=1 instance; returns at the following negedge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rs, input logic push);
        @(posedge clk);
        #1;
        rst       = rs;
        flush     = fl;
        in_valid  = v;
        instr_in  = ins;
        pc_in     = pc;
        out_ready = ordy;
        if (push) sb_q.push_back('{instr: ins, pc: pc});
        if (fl || rs) sb_q.delete();
        @(negedge clk);
    endtask

    // Monitor: every take must match the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected actual pc=%h required=no output", pc_out);
            end else begin
                exp_item = sb_q.pop_front();
                chk("sb_instr", instr_out, exp_item.instr);
                chk("sb_pc", pc_out, exp_item.pc);
            end
        end
    end

    initial begin
        // Reset held two cycles with valid input present.
        in_valid = 1'b1;
        instr_in = 32'hDEAD_BEEF;
        pc_in    = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_instr", instr_out, NOPW);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_in_ready0", {31'b0, rdy0}, 32'd1);

        // Streaming back-to-back.
        cyc(1, 32'hA0, 32'h0, 1, 0, 0, 1);
        chk("str_ready0", {31'b0, in_ready}, 32'd1);
        chk("str_empty", {31'b0, out_valid}, 32'd0);
        cyc(1, 32'hA1, 32'h4, 1, 0, 0, 1);
        chk("str_lat_pc", pc_out, 32'h0);
        chk("str_ready1", {31'b0, in_ready}, 32'd1);
        cyc(1, 32'hA2, 32'h8, 1, 0, 0, 1);
        chk("str_pc1", pc_out, 32'h4);
        cyc(1, 32'hA3, 32'hC, 1, 0, 0, 1);
        chk("str_ready3", {31'b0, in_ready}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("str_pc3", pc_out, 32'hC);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("str_idle_valid", {31'b0, out_valid}, 32'd0);
        chk("str_idle_instr", instr_out, NOPW);

        // Stall into skid, then drain without loss.
        cyc(1, 32'h1000_0100, 32'h100, 0, 0, 0, 1);
        cyc(1, 32'h1000_0104, 32'h104, 0, 0, 0, 1);
        chk("stall_pc_full", pc_out, 32'h100);
        cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
        chk("skid_ready", {31'b0, in_ready}, 32'd0);
        chk("skid_pc", pc_out, 32'h100);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
        cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
        chk("unskid_pc", pc_out, 32'h104);
        chk("unskid_ready", {31'b0, in_ready}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);

        // Flush from SKID with a valid input offered.
        cyc(1, 32'h1000_0300, 32'h300, 0, 0, 0, 1);
        cyc(1, 32'h1000_0304, 32'h304, 0, 0, 0, 1);
        cyc(1, 32'h1000_0200, 32'h200, 0, 1, 0, 0);
        chk("flush_skid_ready", {31'b0, in_ready}, 32'd0);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_instr", instr_out, NOPW);
        chk("flush_pc", pc_out, 32'h0);

        // Flush from FULL drops a same-cycle accept.
        cyc(1, 32'h1000_0210, 32'h210, 0, 0, 0, 1);
        cyc(1, 32'h1000_0220, 32'h220, 1, 1, 0, 0);
        chk("flush_full_ready", {31'b0, in_ready}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("flush_full_valid", {31'b0, out_valid}, 32'd0);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("flush_none_later", {31'b0, out_valid}, 32'd0);

        // Simultaneous accept and take while FULL.
        cyc(1, 32'h1000_0400, 32'h400, 1, 0, 0, 1);
        cyc(1, 32'h1000_0404, 32'h404, 1, 0, 0, 1);
        chk("sim_pc_old", pc_out, 32'h400);
        cyc(0, 32'h0, 32'h0, 0, 0, 0, 0);
        chk("sim_valid", {31'b0, out_valid}, 32'd1);
        chk("sim_pc_new", pc_out, 32'h404);
        chk("sim_instr_new", instr_out, 32'h1000_0404);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);

        // Reset mid-transfer beats flush and discards both entries.
        cyc(1, 32'h1000_0600, 32'h600, 0, 0, 0, 1);
        cyc(1, 32'h1000_0604, 32'h604, 0, 0, 0, 1);
        cyc(1, 32'h1000_0608, 32'h608, 1, 1, 1, 0);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        cyc(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("sb_drain", sb_q.size(), 32'd0);

        // SKID=0 instance: ready follows out_ready_i within the cycle.
        @(posedge clk);
        #1;
        v0 = 1'b1; ins0 = 32'h2000_0500; pci0 = 32'h500; ordy0 = 1'b0;
        @(negedge clk);
        chk("s0_ready_empty", {31'b0, rdy0}, 32'd1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        @(negedge clk);
        chk("s0_valid", {31'b0, ov0}, 32'd1);
        chk("s0_pc", po0, 32'h500);
        chk("s0_ready_stall", {31'b0, rdy0}, 32'd0);
        #1;
        ordy0 = 1'b1; v0 = 1'b1; ins0 = 32'h2000_0504; pci0 = 32'h504;
        #1;
        chk("s0_ready_comb", {31'b0, rdy0}, 32'd1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        @(negedge clk);
        chk("s0_sim_pc", po0, 32'h504);
        chk("s0_sim_instr", io0, 32'h2000_0504);
        @(posedge clk);
        #1;
        ordy0 = 1'b0;
        @(negedge clk);
        chk("s0_empty_valid", {31'b0, ov0}, 32'd0);
        chk("s0_empty_instr", io0, NOPW);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
